spi_master_sched: RTL
=====================

# spi_master_sched

Two-requester SPI master and scheduler sitting in front of the SPI slave/RAM wrapper. It accepts 10-bit command words from two on-chip requesters and arbitrates between them round-robin. It serializes each accepted word onto SS_n/MOSI in the frame format the slave decodes, and for read-data frames it captures the 8-bit MISO reply and returns it to the requester that owns it. It also keeps the slave's single address-latched flag consistent by locking the bus between a requester's read-address and read-data commands.

## Interface
- MISO_START, 15: frame cycle carrying MISO bit 7. It is derived from the slave's rx_valid → RAM tx_valid → MISO path.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  2  per-requester request valid; bit i belongs to requester i.
- req_cmd  in  4  per-requester command; [2i+1:2i] = 00 WR_ADDR, 01 WR_DATA, 10 RD_ADDR, 11 RD_DATA.
- req_data  in  16  per-requester payload; [8i+7:8i].
- req_ready  out  2  grant; combinational; at most one bit high; only in IDLE.
- rsp_valid  out  1  one-cycle pulse: read data or error returned.
- rsp_id  out  1  requester index for the response.
- rsp_err  out  1  RD_DATA was issued with no latched address.
- rsp_data  out  8  captured MISO byte (0 on error).
- SS_n  out  1  slave select, registered.
- MOSI  out  1  serial data, registered.
- MISO  in  1  serial reply from the slave.
- busy  out  1  high whenever state ≠ IDLE.

## Operation
- Transfer rule: a request is transferred when req_valid[i] & req_ready[i]. The word is {cmd, data}, 10 bits.
- States:
  - IDLE: SS_n=1, MOSI=0. Arbitrate; on a transfer, go to SHIFT, or to ERR for an invalid RD_DATA.
  - SHIFT: SS_n=0; frame counter runs.
  - CAPTURE: SS_n=0; RD_DATA frames only.
  - ERR: one cycle; emits the error response.
- Frame cycle k is the k-th cycle with SS_n low, counting from 0.
- MOSI per frame cycle:
  - Cycle 0: 0 (slave leaving IDLE).
  - Cycle 1: word[9] (slave CHK_CMD decode).
  - Cycles 2..11: word[9..0], MSB first.
- Frame end for non-RD_DATA words: SS_n returns high at cycle 12 and the state returns to IDLE. Frame length is 12 low cycles.
- RD_DATA frames:
  - CAPTURE spans cycles 12..MISO_START+7, with MOSI=0.
  - MISO is sampled at the end of cycles MISO_START..MISO_START+7 and shifted in MSB first.
  - SS_n goes high at cycle MISO_START+8, which is 23 with the default.
- Arbitration:
  - Round-robin between the two requesters; the pointer starts at requester 0.
  - After every transfer, the pointer moves to the other requester.
  - A lone valid requester is granted regardless of the pointer.
- Lock:
  - A transferred RD_ADDR sets addr_valid=1 and owner=i.
  - While addr_valid=1, only the owner can be granted. WR_ADDR, WR_DATA and RD_ADDR from the owner are allowed.
  - A transferred RD_DATA clears addr_valid.
- RD_DATA while addr_valid=0: no frame is sent. ERR then gives rsp_valid=1, rsp_err=1, rsp_data=0 and rsp_id=i, after which the state returns to IDLE.
- Reset values:
  - SS_n=1, MOSI=0, rsp_valid=0, rsp_id=0, rsp_err=0, rsp_data=0, busy=0.
  - addr_valid=0, pointer=0, state IDLE.
- Reset mid-frame: all of the reset values above apply asynchronously. No response is emitted, and the frame is abandoned.

## Timing
- Transfer in cycle T puts SS_n low from T+1 (frame cycle 0).
- Inter-frame gap: at least one cycle with SS_n high, namely the IDLE cycle in which the next grant occurs. Back-to-back writes therefore complete every 13 cycles.
- RD_DATA response: rsp_valid is registered and goes high in the cycle SS_n returns high (frame cycle MISO_START+8), for exactly one cycle.
- Error response: rsp_valid goes high in cycle T+1.
- req_ready is never high outside IDLE and never high for a requester blocked by the lock.
- The frame counter is 5 bits and saturates at the frame end; it does not wrap.

## Structure
- Package spi_sched_pkg holds:
  - The command encodings.
  - The state enum.
  - Frame constants: CMD_CYCLE=1, DATA_FIRST=2, DATA_LAST=11, WR_FRAME_LEN=12.
- Sub-module spi_rr_arb implements the 2-way round-robin arbiter. Inputs: valid[1:0], mask[1:0] (lock), advance. Outputs: grant[1:0] and pointer.

## Test plan
- Requester 0 sends WR_ADDR 0x3A → MOSI over frame cycles 0..11 is 0,0,0,0,0,0,1,1,1,0,1,0. SS_n is low for exactly 12 cycles; no rsp_valid.
- Requester 1 sends RD_ADDR 0x05, then RD_DATA 0x00, with a MISO model driving 0xA5 from cycle 15 → SS_n low for 23 cycles. rsp_valid pulses at cycle 23 with rsp_id=1, rsp_data=0xA5, rsp_err=0.
- Both requesters continuously valid with WR_DATA → grants alternate 0,1,0,1, with a one-cycle SS_n-high gap between frames.
- Requester 0 sends RD_ADDR while requester 1 holds WR_DATA valid → requester 1 is not granted until requester 0's RD_DATA frame ends. After that, requester 1 is granted.
- RD_DATA with addr_valid=0 → SS_n stays 1, and at T+1 rsp_valid=1, rsp_err=1, rsp_data=0x00.
- rst_n asserted at frame cycle 5 of a write → SS_n=1 and MOSI=0 immediately, with no response. After release, a fresh WR_ADDR completes normally and is granted to requester 0 first.

Source files
------------

// File: rtl/spi_sched_pkg.sv
// Shared types and frame constants for the two-requester SPI master scheduler.
package spi_sched_pkg;

   localparam int unsigned N_REQ          = 2;
   localparam int unsigned CMD_W          = 2;
   localparam int unsigned DATA_W         = 8;
   localparam int unsigned WORD_W         = CMD_W + DATA_W;
   localparam int unsigned CNT_W          = 5;

   localparam int unsigned CMD_CYCLE      = 1;
   localparam int unsigned DATA_FIRST     = 2;
   localparam int unsigned DATA_LAST      = 11;
   localparam int unsigned WR_FRAME_LEN   = 12;
   localparam int unsigned MISO_START_DEF = 15;

   typedef enum logic [1:0] {
      CMD_WR_ADDR = 2'b00,
      CMD_WR_DATA = 2'b01,
      CMD_RD_ADDR = 2'b10,
      CMD_RD_DATA = 2'b11
   } cmd_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SHIFT,
      ST_CAPTURE,
      ST_ERR
   } state_e;

   typedef struct packed {
      cmd_e               cmd;
      logic [DATA_W-1:0]  data;
   } req_word_t;

   // MOSI level for frame cycle k; cycle 1 previews the word MSB for the slave's command decode.
   function automatic logic mosi_bit(input logic [CNT_W-1:0] k, input req_word_t w);
      logic [WORD_W-1:0] bits;
      logic [CNT_W-1:0]  idx;
      bits     = w;
      idx      = CNT_W'(DATA_LAST) - k;
      mosi_bit = 1'b0;
      if (k == CNT_W'(CMD_CYCLE)) begin
         mosi_bit = bits[WORD_W-1];
      end else if ((k >= CNT_W'(DATA_FIRST)) && (k <= CNT_W'(DATA_LAST))) begin
         mosi_bit = bits[idx[3:0]];
      end
   endfunction

endpackage

// File: rtl/spi_rr_arb.sv
// Two-way round-robin arbiter with a lock mask; pointer moves past the requester just served.
module spi_rr_arb
   import spi_sched_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_REQ-1:0] valid,
   input  logic [N_REQ-1:0] mask,
   input  logic             advance,
   output logic [N_REQ-1:0] grant,
   output logic             pointer
);

   logic [N_REQ-1:0] elig;
   logic             ptr_q;
   logic             ptr_d;

   always_comb begin
      elig  = valid & mask;
      grant = elig;
      if (elig == 2'b11) begin
         grant = ptr_q ? 2'b10 : 2'b01;
      end
   end

   always_comb begin
      ptr_d = ptr_q;
      if (advance && (grant != 2'b00)) begin
         ptr_d = grant[0];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q <= 1'b0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

   assign pointer = ptr_q;

endmodule

// File: rtl/spi_master_sched.sv
// Two-requester SPI master: arbitrates command words, serializes frames on SS_n/MOSI,
// captures read replies from MISO and guards the slave's address-latched flag.
module spi_master_sched
   import spi_sched_pkg::*;
#(
   parameter int unsigned MISO_START = MISO_START_DEF
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [N_REQ-1:0]        req_valid,
   input  logic [N_REQ*CMD_W-1:0]  req_cmd,
   input  logic [N_REQ*DATA_W-1:0] req_data,
   output logic [N_REQ-1:0]        req_ready,
   output logic                    rsp_valid,
   output logic                    rsp_id,
   output logic                    rsp_err,
   output logic [DATA_W-1:0]       rsp_data,
   output logic                    SS_n,
   output logic                    MOSI,
   input  logic                    MISO,
   output logic                    busy
);

   localparam logic [CNT_W-1:0] CAP_FIRST = CNT_W'(MISO_START);
   localparam logic [CNT_W-1:0] CAP_LAST  = CNT_W'(MISO_START + 7);

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   req_word_t         word_q, word_d;
   logic              id_q, id_d;
   logic [DATA_W-1:0] shreg_q, shreg_d;
   logic              addr_valid_q, addr_valid_d;
   logic              owner_q, owner_d;
   logic              ss_q, ss_d;
   logic              mosi_q, mosi_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic              rsp_id_q, rsp_id_d;
   logic              rsp_err_q, rsp_err_d;
   logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
   logic              busy_q, busy_d;

   logic [N_REQ-1:0]  arb_valid;
   logic [N_REQ-1:0]  lock_mask;
   logic [N_REQ-1:0]  grant;
   logic              arb_ptr_unused;
   logic              xfer;
   logic              gid;
   req_word_t         sel_word;

   // Grants only happen in IDLE; a held address restricts grants to its owner.
   always_comb begin
      arb_valid = (state_q == ST_IDLE) ? req_valid : 2'b00;
      lock_mask = 2'b11;
      if (addr_valid_q) begin
         lock_mask = owner_q ? 2'b10 : 2'b01;
      end
   end

   spi_rr_arb u_arb (
      .clk     (clk),
      .rst_n   (rst_n),
      .valid   (arb_valid),
      .mask    (lock_mask),
      .advance (xfer),
      .grant   (grant),
      .pointer (arb_ptr_unused)
   );

   always_comb begin
      req_ready = grant;
      xfer      = |grant;
      gid       = grant[1];
      if (gid) begin
         sel_word.cmd  = cmd_e'(req_cmd[2*CMD_W-1:CMD_W]);
         sel_word.data = req_data[2*DATA_W-1:DATA_W];
      end else begin
         sel_word.cmd  = cmd_e'(req_cmd[CMD_W-1:0]);
         sel_word.data = req_data[DATA_W-1:0];
      end
   end

   // Next-state and registered-output logic; MOSI/SS_n are computed for the upcoming frame cycle.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      word_d       = word_q;
      id_d         = id_q;
      shreg_d      = shreg_q;
      addr_valid_d = addr_valid_q;
      owner_d      = owner_q;
      ss_d         = ss_q;
      mosi_d       = 1'b0;
      rsp_valid_d  = 1'b0;
      rsp_id_d     = rsp_id_q;
      rsp_err_d    = rsp_err_q;
      rsp_data_d   = rsp_data_q;

      case (state_q)
         ST_IDLE: begin
            ss_d = 1'b1;
            if (xfer) begin
               word_d = sel_word;
               id_d   = gid;
               cnt_d  = '0;
               if ((sel_word.cmd == CMD_RD_DATA) && !addr_valid_q) begin
                  state_d     = ST_ERR;
                  rsp_valid_d = 1'b1;
                  rsp_err_d   = 1'b1;
                  rsp_data_d  = '0;
                  rsp_id_d    = gid;
               end else begin
                  state_d = ST_SHIFT;
                  ss_d    = 1'b0;
                  if (sel_word.cmd == CMD_RD_ADDR) begin
                     addr_valid_d = 1'b1;
                     owner_d      = gid;
                  end else if (sel_word.cmd == CMD_RD_DATA) begin
                     addr_valid_d = 1'b0;
                  end
               end
            end
         end
         ST_SHIFT: begin
            ss_d  = 1'b0;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(DATA_LAST)) begin
               if (word_q.cmd == CMD_RD_DATA) begin
                  state_d = ST_CAPTURE;
               end else begin
                  state_d = ST_IDLE;
                  ss_d    = 1'b1;
               end
            end else begin
               mosi_d = mosi_bit(cnt_q + CNT_W'(1), word_q);
            end
         end
         ST_CAPTURE: begin
            ss_d  = 1'b0;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q >= CAP_FIRST) begin
               shreg_d = {shreg_q[DATA_W-2:0], MISO};
            end
            if (cnt_q == CAP_LAST) begin
               state_d     = ST_IDLE;
               ss_d        = 1'b1;
               rsp_valid_d = 1'b1;
               rsp_err_d   = 1'b0;
               rsp_id_d    = id_q;
               rsp_data_d  = {shreg_q[DATA_W-2:0], MISO};
            end
         end
         ST_ERR: begin
            state_d = ST_IDLE;
            ss_d    = 1'b1;
         end
         default: begin
            state_d = ST_IDLE;
            ss_d    = 1'b1;
         end
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         word_q       <= '0;
         id_q         <= 1'b0;
         shreg_q      <= '0;
         addr_valid_q <= 1'b0;
         owner_q      <= 1'b0;
         ss_q         <= 1'b1;
         mosi_q       <= 1'b0;
         rsp_valid_q  <= 1'b0;
         rsp_id_q     <= 1'b0;
         rsp_err_q    <= 1'b0;
         rsp_data_q   <= '0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         word_q       <= word_d;
         id_q         <= id_d;
         shreg_q      <= shreg_d;
         addr_valid_q <= addr_valid_d;
         owner_q      <= owner_d;
         ss_q         <= ss_d;
         mosi_q       <= mosi_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_id_q     <= rsp_id_d;
         rsp_err_q    <= rsp_err_d;
         rsp_data_q   <= rsp_data_d;
         busy_q       <= busy_d;
      end
   end

   assign SS_n      = ss_q;
   assign MOSI      = mosi_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_id    = rsp_id_q;
   assign rsp_err   = rsp_err_q;
   assign rsp_data  = rsp_data_q;
   assign busy      = busy_q;

endmodule
